// File: rtl/hazard_if.sv
// Hazard-unit bundle: pipeline register fields in, stall/flush/forward controls out.
// The pipeline is the master; the hazard control unit is the slave.
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             mem_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               mem_branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_flush, ex_mem_flush,
               forward_a, forward_b, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               mem_branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_flush, ex_mem_flush,
               forward_a, forward_b, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Five-stage pipeline hazard control: load-use stall, branch flush, data-memory
// wait with timeout, operand forwarding and a saturating stall counter.
module hazard_control_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0] fl;   // {if_id, id_ex, ex_mem}
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    logic mem_wait;
    logic load_use;
    logic run_rules;

    assign mem_wait  = hz.dmem_req && !hz.dmem_ready;
    assign load_use  = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                       ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
    // A MEM_WAIT cycle whose access completes is treated exactly like a RUN cycle.
    assign run_rules = (state == RUN) || ((state == MEM_WAIT) && hz.dmem_ready);

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.mem_reg_write && (hz.mem_rd != 5'd0) && (hz.mem_rd == rs))
            return 2'b10;
        else if (hz.wb_reg_write && (hz.wb_rd != 5'd0) && (hz.wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        en    = 5'b11111;
        fl    = 3'b000;
        fwd_a = fwd_sel(hz.ex_rs1);
        fwd_b = fwd_sel(hz.ex_rs2);
        if (rst) begin
            en    = 5'b00000;
            fl    = 3'b111;
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end else if (!run_rules || mem_wait) begin
            en = 5'b00000;
        end else if (hz.mem_branch_taken) begin
            fl = 3'b111;
        end else if (load_use) begin
            en = 5'b00111;
            fl = 3'b010;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (!en[4] && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        state    <= ERROR;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERROR: state <= ERROR;
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign hz.pc_write     = en[4];
    assign hz.if_id_write  = en[3];
    assign hz.id_ex_write  = en[2];
    assign hz.ex_mem_write = en[1];
    assign hz.mem_wb_write = en[0];
    assign hz.if_id_flush  = fl[2];
    assign hz.id_ex_flush  = fl[1];
    assign hz.ex_mem_flush = fl[0];
    assign hz.forward_a    = fwd_a;
    assign hz.forward_b    = fwd_b;
    assign hz.mem_timeout  = (state == ERROR);
    assign hz.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: each stimulus step queues its expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_hazard_control_unit;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_if #(.CNT_W(CNT_W)) hz ();

    hazard_control_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    typedef struct {
        string            tag;
        logic [4:0]       en;
        logic [2:0]       fl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             to;
        logic [CNT_W-1:0] st;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    logic [CNT_W-1:0] exp_stall = '0;
    int               n_checks  = 0;
    int               n_pass    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "/en"},
                  32'({hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write, hz.mem_wb_write}),
                  32'(mon_e.en));
            check({mon_e.tag, "/flush"},
                  32'({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}), 32'(mon_e.fl));
            check({mon_e.tag, "/fwd_a"}, 32'(hz.forward_a), 32'(mon_e.fa));
            check({mon_e.tag, "/fwd_b"}, 32'(hz.forward_b), 32'(mon_e.fb));
            check({mon_e.tag, "/timeout"}, 32'(hz.mem_timeout), 32'(mon_e.to));
            check({mon_e.tag, "/stalls"}, 32'(hz.stall_cycles), 32'(mon_e.st));
        end
    end

    task automatic clear_inputs();
        hz.id_rs1 = 5'd0;  hz.id_rs2 = 5'd0;
        hz.ex_rs1 = 5'd0;  hz.ex_rs2 = 5'd0;
        hz.ex_rd  = 5'd0;  hz.ex_mem_read = 1'b0;
        hz.mem_rd = 5'd0;  hz.mem_reg_write = 1'b0;
        hz.wb_rd  = 5'd0;  hz.wb_reg_write  = 1'b0;
        hz.mem_branch_taken = 1'b0;
        hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    // Queue the expected outputs for the current cycle, then advance one clock and
    // update the reference stall count from what that cycle should have done.
    task automatic step(input string tag, input logic [4:0] en, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic to);
        exp_t e;
        e.tag = tag; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.to = to;
        e.st  = exp_stall;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst)
            exp_stall = '0;
        else if (!en[4] && (exp_stall != {CNT_W{1'b1}}))
            exp_stall = exp_stall + 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Forwarding candidates present during reset must still read as 00.
        hz.mem_rd = 5'd7; hz.mem_reg_write = 1'b1; hz.ex_rs1 = 5'd7;
        step("reset", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        rst = 1'b0;
        step("idle", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5;
        step("lu_rs2", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        step("lu_done", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
        step("ld_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
        hz.ex_rd = 5'd6; hz.id_rs1 = 5'd3; hz.id_rs2 = 5'd4;
        step("ld_nomatch", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
        hz.ex_rd = 5'd9; hz.id_rs1 = 5'd9;
        step("lu_rs1", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
        hz.mem_branch_taken = 1'b1;
        step("br_lu", 5'b11111, 3'b111, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        step("br_done", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        hz.mem_rd = 5'd7; hz.wb_rd = 5'd7; hz.mem_reg_write = 1'b1; hz.wb_reg_write = 1'b1;
        hz.ex_rs1 = 5'd7; hz.ex_rs2 = 5'd7;
        step("fwd_mem", 5'b11111, 3'b000, 2'b10, 2'b10, 1'b0);
        hz.mem_reg_write = 1'b0;
        step("fwd_wb", 5'b11111, 3'b000, 2'b01, 2'b01, 1'b0);
        hz.ex_rs1 = 5'd0;
        step("fwd_none", 5'b11111, 3'b000, 2'b00, 2'b01, 1'b0);
        hz.wb_rd = 5'd0; hz.ex_rs2 = 5'd0;
        step("fwd_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
        clear_inputs();

        // Memory wait beats a taken branch; forwarding keeps working while frozen.
        hz.mem_rd = 5'd4; hz.mem_reg_write = 1'b1; hz.ex_rs1 = 5'd4;
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0; hz.mem_branch_taken = 1'b1;
        step("mw_run", 5'b00000, 3'b000, 2'b10, 2'b00, 1'b0);
        hz.mem_branch_taken = 1'b0;
        step("mw_1", 5'b00000, 3'b000, 2'b10, 2'b00, 1'b0);
        step("mw_2", 5'b00000, 3'b000, 2'b10, 2'b00, 1'b0);
        hz.dmem_ready = 1'b1;
        step("mw_ready", 5'b11111, 3'b000, 2'b10, 2'b00, 1'b0);
        clear_inputs();
        step("mw_done", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        step("mwl_run", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
        hz.dmem_ready = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd12; hz.id_rs1 = 5'd12;
        step("mwl_ready", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        step("mwl_done", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        hz.dmem_req = 1'b1;
        step("mwr_run", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
        rst = 1'b1;
        step("mwr_rst", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        clear_inputs();
        step("mwr_idle", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        // Timeout: the 16th waiting cycle in MEM_WAIT moves to ERROR; the counter saturates.
        hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
        step("to_run", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < MAX_WAIT; i++)
            step($sformatf("to_wait%0d", i), 5'b00000, 3'b000, 2'b00, 2'b00, 1'b0);
        step("to_err", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
        hz.dmem_req = 1'b0; hz.dmem_ready = 1'b1; hz.mem_branch_taken = 1'b1;
        step("to_stuck", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
        clear_inputs();
        rst = 1'b1;
        step("to_rst", 5'b00000, 3'b111, 2'b00, 2'b00, 1'b1);
        rst = 1'b0;
        step("to_clear", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end
endmodule
